// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Brief    : Button-driven time/alarm entry controller. Turns set/inc/dec
//            push-buttons into a validated BCD hh:mm value and issues a
//            one-cycle LD_time or LD_alarm strobe towards the alarm clock.
//            Edits start from the displayed time (or the last committed
//            alarm) and are abandoned after TIMEOUT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl #(
  parameter int TIMEOUT    = 30,
  parameter int REPEAT_DLY = 2
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       sel_alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] field
);

  // Idle counter only needs to hold 0 .. TIMEOUT-1; the repeat counter
  // saturates at REPEAT_DLY.
  localparam int IDLE_W = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
  localparam int REP_W  = (REPEAT_DLY < 2) ? 1 : $clog2(REPEAT_DLY + 1);

  localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(TIMEOUT - 1);
  localparam logic [REP_W-1:0]  c_rep_sat   = REP_W'(REPEAT_DLY);

  localparam logic [1:0] c_field_none = 2'b00;
  localparam logic [1:0] c_field_hour = 2'b01;
  localparam logic [1:0] c_field_min  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EDIT_HR  = 2'd1,
    S_EDIT_MIN = 2'd2,
    S_COMMIT   = 2'd3
  } state_t;

  state_t            r_state;

  // Button history and auto-repeat bookkeeping
  logic              r_set_q;
  logic              r_inc_q;
  logic              r_dec_q;
  logic [REP_W-1:0]  r_rep_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;

  // Edit buffer, commit target and alarm shadow
  logic              r_target;
  logic [1:0]        r_buf_h1;
  logic [3:0]        r_buf_h0;
  logic [3:0]        r_buf_m1;
  logic [3:0]        r_buf_m0;
  logic [1:0]        r_sh_h1;
  logic [3:0]        r_sh_h0;
  logic [3:0]        r_sh_m1;
  logic [3:0]        r_sh_m0;

  // Decoded button events
  logic              w_set_edge;
  logic              w_inc_act;
  logic              w_dec_act;
  logic              w_up;
  logic              w_dn;
  logic              w_step;

  // Entry source after selection
  logic [1:0]        w_src_h1;
  logic [3:0]        w_src_h0;
  logic [3:0]        w_src_m1;
  logic [3:0]        w_src_m0;
  logic              w_src_ok;

  // Buffer value after one +/-1 step on the active field
  logic [1:0]        w_hr_h1;
  logic [3:0]        w_hr_h0;
  logic [3:0]        w_mn_m1;
  logic [3:0]        w_mn_m0;

  // Turn button levels into actions; pressing inc and dec together cancels out
  always_comb begin
    w_set_edge = btn_set & ~r_set_q;
    w_inc_act  = btn_inc & (~r_inc_q | (r_rep_cnt >= c_rep_sat));
    w_dec_act  = btn_dec & (~r_dec_q | (r_rep_cnt >= c_rep_sat));
    w_up       = w_inc_act & ~btn_dec;
    w_dn       = w_dec_act & ~btn_inc;
    w_step     = w_up | w_dn;
  end

  // Pick the entry source and reject anything that is not a legal hh:mm
  always_comb begin
    w_src_h1 = sel_alarm ? r_sh_h1 : cur_H1;
    w_src_h0 = sel_alarm ? r_sh_h0 : cur_H0;
    w_src_m1 = sel_alarm ? r_sh_m1 : cur_M1;
    w_src_m0 = sel_alarm ? r_sh_m0 : cur_M0;
    w_src_ok = (w_src_h0 <= 4'd9) && (w_src_m1 <= 4'd5) && (w_src_m0 <= 4'd9) &&
               ((w_src_h1 < 2'd2) || ((w_src_h1 == 2'd2) && (w_src_h0 <= 4'd3)));
  end

  // Digit-wise BCD hour step with 23 <-> 00 wrap
  always_comb begin
    w_hr_h1 = r_buf_h1;
    w_hr_h0 = r_buf_h0;
    if (w_up) begin
      if ((r_buf_h1 == 2'd2) && (r_buf_h0 == 4'd3)) begin
        w_hr_h1 = 2'd0;
        w_hr_h0 = 4'd0;
      end else if (r_buf_h0 == 4'd9) begin
        w_hr_h1 = r_buf_h1 + 2'd1;
        w_hr_h0 = 4'd0;
      end else begin
        w_hr_h0 = r_buf_h0 + 4'd1;
      end
    end else if (w_dn) begin
      if ((r_buf_h1 == 2'd0) && (r_buf_h0 == 4'd0)) begin
        w_hr_h1 = 2'd2;
        w_hr_h0 = 4'd3;
      end else if (r_buf_h0 == 4'd0) begin
        w_hr_h1 = r_buf_h1 - 2'd1;
        w_hr_h0 = 4'd9;
      end else begin
        w_hr_h0 = r_buf_h0 - 4'd1;
      end
    end
  end

  // Digit-wise BCD minute step with 59 <-> 00 wrap
  always_comb begin
    w_mn_m1 = r_buf_m1;
    w_mn_m0 = r_buf_m0;
    if (w_up) begin
      if (r_buf_m0 == 4'd9) begin
        w_mn_m0 = 4'd0;
        w_mn_m1 = (r_buf_m1 == 4'd5) ? 4'd0 : (r_buf_m1 + 4'd1);
      end else begin
        w_mn_m0 = r_buf_m0 + 4'd1;
      end
    end else if (w_dn) begin
      if (r_buf_m0 == 4'd0) begin
        w_mn_m0 = 4'd9;
        w_mn_m1 = (r_buf_m1 == 4'd0) ? 4'd5 : (r_buf_m1 - 4'd1);
      end else begin
        w_mn_m0 = r_buf_m0 - 4'd1;
      end
    end
  end

  // Button history plus a hold counter that clears on release and saturates
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_set_q   <= 1'b0;
      r_inc_q   <= 1'b0;
      r_dec_q   <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_set_q <= btn_set;
      r_inc_q <= btn_inc;
      r_dec_q <= btn_dec;
      if (btn_inc | btn_dec) begin
        if (r_rep_cnt < c_rep_sat) begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
      end else begin
        r_rep_cnt <= '0;
      end
    end
  end

  // Edit state machine: entry, field edits, timeout, commit and strobes
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
      r_target   <= 1'b0;
      r_buf_h1   <= 2'd0;
      r_buf_h0   <= 4'd0;
      r_buf_m1   <= 4'd0;
      r_buf_m0   <= 4'd0;
      r_sh_h1    <= 2'd0;
      r_sh_h0    <= 4'd0;
      r_sh_m1    <= 4'd0;
      r_sh_m0    <= 4'd0;
      H_in1      <= 2'd0;
      H_in0      <= 4'd0;
      M_in1      <= 4'd0;
      M_in0      <= 4'd0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      editing    <= 1'b0;
      field      <= c_field_none;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_set_edge) begin
            r_target   <= sel_alarm;
            r_buf_h1   <= w_src_ok ? w_src_h1 : 2'd0;
            r_buf_h0   <= w_src_ok ? w_src_h0 : 4'd0;
            r_buf_m1   <= w_src_ok ? w_src_m1 : 4'd0;
            r_buf_m0   <= w_src_ok ? w_src_m0 : 4'd0;
            r_idle_cnt <= '0;
            r_state    <= S_EDIT_HR;
            editing    <= 1'b1;
            field      <= c_field_hour;
          end
        end

        S_EDIT_HR: begin
          if (w_set_edge) begin
            r_idle_cnt <= '0;
            r_state    <= S_EDIT_MIN;
            field      <= c_field_min;
          end else if (w_step) begin
            r_buf_h1   <= w_hr_h1;
            r_buf_h0   <= w_hr_h0;
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == c_idle_last) begin
            r_idle_cnt <= '0;
            r_state    <= S_IDLE;
            editing    <= 1'b0;
            field      <= c_field_none;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end

        S_EDIT_MIN: begin
          if (w_set_edge) begin
            // Data and strobe are presented together for exactly one cycle
            r_idle_cnt <= '0;
            r_state    <= S_COMMIT;
            H_in1      <= r_buf_h1;
            H_in0      <= r_buf_h0;
            M_in1      <= r_buf_m1;
            M_in0      <= r_buf_m0;
            LD_time    <= ~r_target;
            LD_alarm   <= r_target;
            editing    <= 1'b0;
            field      <= c_field_none;
          end else if (w_step) begin
            r_buf_m1   <= w_mn_m1;
            r_buf_m0   <= w_mn_m0;
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == c_idle_last) begin
            r_idle_cnt <= '0;
            r_state    <= S_IDLE;
            editing    <= 1'b0;
            field      <= c_field_none;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end

        S_COMMIT: begin
          // The alarm clock has no alarm read-back, so keep our own copy
          if (r_target) begin
            r_sh_h1 <= r_buf_h1;
            r_sh_h0 <= r_buf_h0;
            r_sh_m1 <= r_buf_m1;
            r_sh_m0 <= r_buf_m0;
          end
          LD_time    <= 1'b0;
          LD_alarm   <= 1'b0;
          r_idle_cnt <= '0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_idle_cnt <= '0;
          r_state    <= S_IDLE;
          LD_time    <= 1'b0;
          LD_alarm   <= 1'b0;
          editing    <= 1'b0;
          field      <= c_field_none;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time/alarm entry controller: the writer side of the alarm clock's load interface. It turns set/inc/dec push-buttons into validated BCD digits on H_in1/H_in0/M_in1/M_in0, plus a single-cycle LD_time or LD_alarm strobe. It sits between the front-panel buttons and the alarm clock, runs on the same 1 s tick, and reads back the clock's current-time BCD outputs so edits start from the displayed time.

## Interface
- TIMEOUT, 30: idle cycles in an edit state before the edit is abandoned.
- REPEAT_DLY, 2: cycles a held inc/dec must stay high after its rising edge before auto-repeat starts.
- clk_1s  in  1  clock, 1 s tick; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- btn_set  in  1  enter edit / advance field / commit (level, synchronous to clk_1s).
- btn_inc  in  1  increment the active field.
- btn_dec  in  1  decrement the active field.
- sel_alarm  in  1  0 = edit time, 1 = edit alarm; sampled only on edit entry.
- cur_H1  in  2  current-time hour tens (BCD).
- cur_H0, cur_M1, cur_M0  in  4 each  current hour units, minute tens, minute units (BCD).
- H_in1  out  2  committed hour tens.
- H_in0, M_in1, M_in0  out  4 each  committed hour units, minute tens, minute units.
- LD_time  out  1  one-cycle load strobe for the time.
- LD_alarm  out  1  one-cycle load strobe for the alarm.
- editing  out  1  high in EDIT_HR and EDIT_MIN.
- field  out  2  00 none, 01 hours, 10 minutes (blink select).

## Operation
- Buttons are registered once (prev copies); an edge means cur=1, prev=0.
- Internal state: edit buffer hh:mm (BCD), target bit, alarm shadow hh:mm (reset 00:00), idle counter, repeat counter.
- IDLE: on a btn_set edge, latch target=sel_alarm. Load the buffer from cur_* if target=0, or from the alarm shadow if target=1. Go to EDIT_HR. A captured value with hour >23, minute >59 or any digit >9 loads as 00:00. inc/dec are ignored in IDLE.
- EDIT_HR: an inc action gives hour+1 with wrap 23→00. A dec action gives hour-1 with wrap 00→23. A btn_set edge goes to EDIT_MIN.
- EDIT_MIN: minute ±1 with wrap 59↔00. A btn_set edge goes to COMMIT.
- COMMIT (one cycle): outputs already hold the buffer; LD_time (target=0) or LD_alarm (target=1) is high. If target=1, the alarm shadow takes the buffer. Next state is IDLE unconditionally.
- The transition into COMMIT registers H_in*/M_in* ← buffer and the strobe ← 1. The transition out clears the strobe. Data outputs change only on entry to COMMIT.
- Action rules: an inc or dec edge is one action. While a button is held, repeat counter ≥ REPEAT_DLY produces one action per cycle. The counter clears on release and saturates.
- Simultaneous events: btn_set edge wins; inc/dec are ignored that cycle. inc and dec both active means no action.
- Timeout: the idle counter clears on state entry and on any action or btn_set edge. When it reaches TIMEOUT in an edit state, go to IDLE with no strobe, and outputs and shadow are unchanged.
- BCD arithmetic is digit-wise. Units 9+1 gives 0 with a carry to tens. Units 0-1 gives 9 with a borrow. Hour tens is checked against 2 for the 23 wrap.

## Timing
- Reset (async): state IDLE; H_in1=0, H_in0=0, M_in1=0, M_in0=0, LD_time=0, LD_alarm=0, editing=0, field=00; buffer, shadow and counters 0.
- Reset while in an edit state or in COMMIT aborts immediately; no strobe is issued after reset.
- A btn_set edge sampled at edge N puts the block in EDIT_HR at N+1 (editing=1, field=01).
- The btn_set edge that commits is sampled at edge N. The strobe and new data are valid from N+1 to N+2. The alarm clock loads them at edge N+2.
- LD_time and LD_alarm are never high together and never high for more than 1 cycle.
- Held inc: the edge at N acts at N. With REPEAT_DLY=2, held-button actions occur at N+2, N+3, and so on.

## Test plan
- Reset, cur=12:34, sel_alarm=0. Sequence: set, inc×3 (hr), set, dec×1 (min), set → one-cycle LD_time with H_in=1,5 and M_in=3,3; LD_alarm stays 0.
- Hour wrap: entry at 23:59, inc once in EDIT_HR → 00. Minute: inc → 00; from 00, dec → 59. Commit → outputs 0,0,5,9.
- Alarm path: sel_alarm=1, set 07:30 and commit → LD_alarm pulse only. Re-enter with sel_alarm=1 → buffer starts at 07:30, not cur_*.
- Timeout: enter edit, then no buttons for 30 cycles → back to IDLE, no strobe, outputs unchanged. A single inc at cycle 29 restarts the count.
- Auto-repeat and conflicts: hold inc 5 cycles in EDIT_MIN from 10 → 14. inc+dec together → no change. set+inc in the same cycle → advance only, no increment.
- Reset asserted in COMMIT mid-strobe → LD_time=0 immediately, outputs 00:00, state IDLE.
